// File: rtl/sccb_responder.sv
// rtl/sccb_responder.sv - SCCB/I2C-style responder exposing a byte-wide register access port
// Decodes 3-phase writes and 2-phase read transactions; the sub-address persists across transactions.
module sccb_responder #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_reg_addr,
  output logic       o_wr_en,
  output logic [7:0] o_wr_data,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic       byte_full_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic [7:0] reg_addr_q;
  logic       wr_en_q;
  logic [7:0] wr_data_q;

  // Synchronisers reset to the idle-bus level so reset release never fakes an event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sda};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SCL must be high in both samples, so a coincident SCL edge counts as a data change.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      byte_full_q <= 1'b0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= 8'h00;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;
      if (start_det || stop_det) begin
        state_q     <= start_det ? ID : IDLE;
        bit_cnt_q   <= 3'd0;
        byte_full_q <= 1'b0;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b0;
      end else if (scl_rise) begin
        if (state_q == ID || state_q == ADDR || state_q == WDATA) begin
          shift_q   <= {shift_q[6:0], sda_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_full_q <= 1'b1;
        end
      end else if (scl_fall) begin
        case (state_q)
          ID: if (byte_full_q) begin
            byte_full_q <= 1'b0;
            if (shift_q[7:1] == DEVICE_ID[7:1]) begin
              state_q  <= ID_ACK;
              rw_q     <= shift_q[0];
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q <= IGNORE;
            end
          end
          ID_ACK: if (rw_q) begin
            // Bit 7 goes out now; the remaining seven follow on later falls.
            shift_q   <= {i_reg_rdata[6:0], 1'b0};
            sda_oe_q  <= ~i_reg_rdata[7];
            bit_cnt_q <= 3'd0;
            state_q   <= RDATA;
          end else begin
            sda_oe_q <= 1'b0;
            state_q  <= ADDR;
          end
          ADDR: if (byte_full_q) begin
            byte_full_q <= 1'b0;
            reg_addr_q  <= shift_q;
            sda_oe_q    <= 1'b1;
            state_q     <= ADDR_ACK;
          end
          ADDR_ACK: begin
            sda_oe_q <= 1'b0;
            state_q  <= WDATA;
          end
          WDATA: if (byte_full_q) begin
            byte_full_q <= 1'b0;
            wr_en_q     <= 1'b1;
            wr_data_q   <= shift_q;
            sda_oe_q    <= 1'b1;
            state_q     <= WDATA_ACK;
          end
          WDATA_ACK: begin
            sda_oe_q <= 1'b0;
            state_q  <= IGNORE;
          end
          RDATA: if (bit_cnt_q == 3'd7) begin
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= 3'd0;
            state_q   <= RDATA_ACK;
          end else begin
            sda_oe_q  <= ~shift_q[7];
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
          RDATA_ACK: state_q <= IGNORE;
          default: ;
        endcase
      end
    end
  end

  assign o_sda_oe   = sda_oe_q;
  assign o_reg_addr = reg_addr_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// tb/tb_sccb_responder.sv - self-checking bench for sccb_responder
// Drives SCCB transactions from a table plus hand-written read, abort and reset sequences.
module tb_sccb_responder;

  logic       clk, rst, scl, sda_m;
  logic [7:0] rdata;
  logic       sda_oe, wr_en, busy;
  logic [7:0] reg_addr, wr_data;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  sccb_responder #(.DEVICE_ID(8'h42), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_line),
    .o_sda_oe(sda_oe), .o_reg_addr(reg_addr), .o_wr_en(wr_en),
    .o_wr_data(wr_data), .i_reg_rdata(rdata), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         oe_cycles = 0;
  logic [7:0] last_wr_addr, last_wr_data;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      last_wr_addr = reg_addr;
      last_wr_data = wr_data;
    end
    if (sda_oe) oe_cycles++;
  end

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [3:0]  exp_ack;
    int          exp_wr;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic oe);
    #40 sda_m = b;
    #40 scl = 1'b1;
    #40 oe = sda_oe;
    #40 scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic oe;
    for (int i = 7; i >= 0; i--) send_bit(d[i], oe);
    send_bit(1'b1, ack);
  endtask

  task automatic do_start;
    #40 sda_m = 1'b0;
    #40 scl = 1'b0;
  endtask

  task automatic rep_start;
    #40 sda_m = 1'b1;
    #40 scl = 1'b1;
    #40 sda_m = 1'b0;
    #40 scl = 1'b0;
  endtask

  task automatic do_stop;
    #40 sda_m = 1'b0;
    #40 scl = 1'b1;
    #40 sda_m = 1'b1;
    #40;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, oe;
    logic [7:0] rd;
    int         wr0, oe0;

    vecs[0] = '{32'h4212_8000, 3, 4'b0111, 1, 8'h12, 8'h80, 1'b1};
    vecs[1] = '{32'h6012_5500, 3, 4'b0000, 0, 8'h12, 8'h00, 1'b0};
    vecs[2] = '{32'h4433_2200, 3, 4'b0000, 0, 8'h12, 8'h00, 1'b0};
    vecs[3] = '{32'h425C_A5FF, 4, 4'b0111, 1, 8'h5C, 8'hA5, 1'b1};
    vecs[4] = '{32'h420A_0000, 2, 4'b0011, 0, 8'h0A, 8'h00, 1'b1};

    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; rdata = 8'h76;
    #53;
    chk("rst sda_oe", sda_oe, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst reg_addr", reg_addr, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    #200;
    chk("idle sda_oe", sda_oe, 0);
    chk("idle busy", busy, 0);
    chk("idle wr_cnt", wr_cnt, 0);

    for (int v = 0; v < 5; v++) begin
      wr0 = wr_cnt;
      oe0 = oe_cycles;
      do_start;
      for (int k = 0; k < vecs[v].n; k++) begin
        send_byte(vecs[v].bytes[31-8*k -: 8], ack);
        chk($sformatf("vec%0d ack%0d", v, k), ack, vecs[v].exp_ack[k]);
        if (k == 0) chk($sformatf("vec%0d busy", v), busy, vecs[v].exp_busy);
      end
      do_stop;
      #100;
      chk($sformatf("vec%0d wr count", v), wr_cnt - wr0, vecs[v].exp_wr);
      chk($sformatf("vec%0d reg_addr", v), reg_addr, vecs[v].exp_addr);
      if (vecs[v].exp_wr > 0) begin
        chk($sformatf("vec%0d wr addr", v), last_wr_addr, vecs[v].exp_addr);
        chk($sformatf("vec%0d wr data", v), last_wr_data, vecs[v].exp_data);
      end
      chk($sformatf("vec%0d busy after stop", v), busy, 0);
      chk($sformatf("vec%0d sda driven", v), oe_cycles != oe0, vecs[v].exp_ack != 0);
    end

    // Read back from sub-address 0A set by the last table entry.
    wr0 = wr_cnt;
    do_start;
    send_byte(8'h43, ack);
    chk("read id ack", ack, 1);
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, oe);
      rd[i] = ~oe;
      if (i == 4) chk("read busy", busy, 1);
    end
    chk("read data", rd, 8'h76);
    send_bit(1'b1, oe);
    chk("read nack released", oe, 0);
    do_stop;
    #100;
    chk("read reg_addr", reg_addr, 8'h0A);
    chk("read no strobe", wr_cnt - wr0, 0);
    chk("read busy after stop", busy, 0);

    // Repeated START after five data bits discards the partial byte.
    wr0 = wr_cnt;
    do_start;
    send_byte(8'h42, ack);
    send_byte(8'h55, ack);
    for (int i = 0; i < 5; i++) send_bit(1'b1, oe);
    rep_start;
    #100;
    chk("abort busy", busy, 0);
    chk("abort no strobe", wr_cnt - wr0, 0);
    chk("abort reg_addr", reg_addr, 8'h55);
    send_byte(8'h42, ack);
    send_byte(8'h3A, ack);
    send_byte(8'h04, ack);
    chk("restart data ack", ack, 1);
    do_stop;
    #100;
    chk("restart one strobe", wr_cnt - wr0, 1);
    chk("restart wr addr", last_wr_addr, 8'h3A);
    chk("restart wr data", last_wr_data, 8'h04);

    // Reset while the responder is driving a read 0 bit.
    do_start;
    send_byte(8'h43, ack);
    #40 sda_m = 1'b1;
    #40 scl = 1'b1;
    #40 chk("pre-reset driving", sda_oe, 1);
    rst = 1'b1;
    #10;
    chk("reset releases sda", sda_oe, 0);
    chk("reset busy", busy, 0);
    chk("reset reg_addr", reg_addr, 0);
    #20 rst = 1'b0;
    #40 scl = 1'b0;
    do_stop;
    wr0 = wr_cnt;
    do_start;
    send_byte(8'h42, ack);
    send_byte(8'h77, ack);
    send_byte(8'h99, ack);
    chk("post-reset ack", ack, 1);
    do_stop;
    #100;
    chk("post-reset strobe", wr_cnt - wr0, 1);
    chk("post-reset wr addr", last_wr_addr, 8'h77);
    chk("post-reset wr data", last_wr_data, 8'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
